// File: rtl/ibuf_bank_loader.sv
// Write-side sequencer for the input-buffer SRAM banks: accepts a tile
// config, then scatters a word stream round-robin across NBANK banks.
module ibuf_bank_loader #(
  parameter int DWD   = 16,
  parameter int NBANK = 4,
  parameter int DEPTH = 256,
  parameter int LENWD = 16,
  parameter int AWD   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             cfg_rdy,
  output logic             cfg_ack,
  input  logic [AWD-1:0]   i_cfg_base,
  input  logic [LENWD-1:0] i_cfg_len,
  input  logic             src_rdy,
  output logic             src_ack,
  input  logic [DWD-1:0]   i_src_data,
  output logic [NBANK-1:0] o_ce,
  output logic             o_rw,
  output logic [AWD-1:0]   o_addr,
  output logic [DWD-1:0]   o_wdata,
  output logic             done_rdy,
  input  logic             done_ack,
  output logic             o_err,
  output logic             o_busy
);

  // state | meaning
  // IDLE  | waiting for a tile config (cfg_ack high)
  // LOAD  | accepting stream words, one bank write per word (src_ack high)
  // DONE  | tile written, holding done_rdy until done_ack

  localparam int BWD = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam logic [32:0] CAP = 33'(NBANK) * 33'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BWD-1:0]   bank_q;
  logic [AWD-1:0]   row_q;
  logic [LENWD-1:0] cnt_q;
  logic [LENWD-1:0] len_q;
  logic [NBANK-1:0] ce_q;
  logic             rw_q;
  logic [AWD-1:0]   addr_q;
  logic [DWD-1:0]   wdata_q;
  logic             err_q;

  logic cfg_xfer;
  logic src_xfer;
  logic last_word;

  assign cfg_xfer  = cfg_rdy & cfg_ack;
  assign src_xfer  = src_rdy & src_ack;
  assign last_word = (cnt_q == (len_q - LENWD'(1)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake acks are decoded from state only, never from the rdy inputs.
  always_comb begin
    state_d  = state_q;
    cfg_ack  = 1'b0;
    src_ack  = 1'b0;
    done_rdy = 1'b0;
    case (state_q)
      S_IDLE: begin
        cfg_ack = 1'b1;
        if (cfg_rdy) begin
          state_d = (i_cfg_len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        src_ack = 1'b1;
        if (src_rdy && last_word) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_rdy = 1'b1;
        if (done_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bank_q  <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ce_q    <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ce_q <= '0;
      rw_q <= 1'b0;
      if (cfg_xfer) begin
        len_q  <= i_cfg_len;
        row_q  <= i_cfg_base;
        bank_q <= '0;
        cnt_q  <= '0;
        err_q  <= (33'(i_cfg_len) > CAP);
      end
      if (src_xfer) begin
        ce_q    <= NBANK'(1) << bank_q;
        rw_q    <= 1'b1;
        addr_q  <= row_q;
        wdata_q <= i_src_data;
        cnt_q   <= cnt_q + LENWD'(1);
        // Overlength tiles simply wrap the row and overwrite earlier data.
        if (bank_q == BWD'(NBANK - 1)) begin
          bank_q <= '0;
          row_q  <= (row_q == AWD'(DEPTH - 1)) ? '0 : row_q + AWD'(1);
        end else begin
          bank_q <= bank_q + BWD'(1);
        end
      end
    end
  end

  assign o_ce    = ce_q;
  assign o_rw    = rw_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_err   = err_q;
  assign o_busy  = (state_q != S_IDLE);

endmodule
